upper_layer_egress: RTL
=======================

# upper_layer_egress

Logical-layer block that delivers received, descrambled lane bytes to the transport layer over the upper-layer interface. It buffers bytes from the lane receive path in a FIFO and presents them on `transport_layer_data_out` with the `enable_receive` valid strobe. Delivery is paced according to `generation_speed` and gated by the link `phase`. It is the receive-direction counterpart of the `transport_layer_data_in` / `enable_sending` path.

## Interface
Parameters:
- `DEPTH`, 16: FIFO depth in bytes; power of two, minimum 4.
- `ACTIVE_PHASE`, 3'd5: `phase` value meaning the link is in data transfer (CL0).

Ports:
- `clk`  in  1  single block clock.
- `reset`  in  1  synchronous, active-high reset.
- `phase`  in  3  current link-training phase.
- `generation_speed`  in  2  GEN encoding: 0 = gen2, 1 = gen3, 2 = gen4; 3 is treated as gen4.
- `lane_data_in`  in  8  received byte from the lane path.
- `lane_data_valid`  in  1  `lane_data_in` is valid this cycle. There is no backpressure to the lane side.
- `transport_layer_data_out`  out  8  byte to the transport layer.
- `enable_receive`  out  1  `transport_layer_data_out` is valid.
- `transport_ready`  in  1  the transport layer accepts the byte this cycle.
- `overflow`  out  1  sticky flag: a byte was dropped because the FIFO was full.
- `byte_count`  out  16  bytes delivered. Present only with `UL_EGRESS_STATS_EN`.

## Operation
- State machine has three states: IDLE, ACTIVE, FLUSH.
  - IDLE → ACTIVE when `phase == ACTIVE_PHASE`.
  - ACTIVE → FLUSH when `phase != ACTIVE_PHASE`.
  - FLUSH → IDLE unconditionally after 1 cycle.
- Write path:
  - In ACTIVE, `lane_data_valid` writes `lane_data_in` when the FIFO is not full.
  - Fullness is taken from the registered occupancy at the start of the cycle. A write while full is dropped even if a read happens in the same cycle.
  - A dropped write sets `overflow`.
  - In IDLE and FLUSH, `lane_data_valid` is ignored and `overflow` is not set.
- Read path:
  - `enable_receive` is asserted in ACTIVE when the FIFO is non-empty and the pace counter is 0.
  - A byte transfers on a cycle with `enable_receive && transport_ready`.
  - While `enable_receive` is high and not accepted, `transport_layer_data_out` and `enable_receive` hold stable.
- Pacing:
  - On each transfer, the pace counter loads PERIOD-1, where PERIOD = 4 for gen2, 2 for gen3, 1 for gen4.
  - The counter decrements to 0 and saturates there.
  - A `generation_speed` change takes effect at the next load.
- FLUSH:
  - Resets the FIFO pointers, occupancy and pace counter.
  - Deasserts `enable_receive`; `transport_layer_data_out` goes to 0.
  - Bytes still in the FIFO are discarded.
- `overflow`:
  - Cleared by `reset`.
  - Cleared on the IDLE → ACTIVE transition.
  - Otherwise holds.
- Occupancy: a counter of width log2(DEPTH)+1. Simultaneous write and read leaves occupancy unchanged. Pointers wrap modulo DEPTH.

## Timing
- All outputs are registered.
- Reset values: `transport_layer_data_out` = 0, `enable_receive` = 0, `overflow` = 0, `byte_count` = 0. State is IDLE, FIFO empty, pace counter 0.
- Reset takes priority over all other events in the same cycle.
- Latency: a byte written at edge N into an empty FIFO shows `enable_receive` = 1 from edge N+1 in gen4 with the pace counter at 0.
- The phase change that takes the block out of ACTIVE is seen at edge N; `enable_receive` is 0 from edge N+1 (FLUSH).
- Gen4 with `transport_ready` held high gives sustained throughput of 1 byte/cycle. Gen3 gives 1 byte per 2 cycles; gen2 gives 1 byte per 4 cycles.
- `overflow` rises the cycle after the dropped write.

## Configuration
- `UL_EGRESS_STATS_EN` defined:
  - Adds the `byte_count` output.
  - 16-bit count of accepted output transfers, wrapping 16'hFFFF → 0.
  - Reset to 0 by `reset` only; holds through FLUSH.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

## Test plan
- Gen4, phase=5, write 0x11, 0x22, 0x33 on consecutive cycles, `transport_ready`=1 → `enable_receive` high for 3 consecutive cycles delivering 0x11, 0x22, 0x33 in order, first one cycle after the first write.
- Gen2, 8 bytes preloaded, `transport_ready`=1 → one transfer every 4 cycles; gen3 → every 2 cycles.
- `transport_ready`=0 for 5 cycles with data 0xA5 pending → `enable_receive` and 0xA5 held stable for all 5 cycles; transfer happens on the first ready cycle.
- DEPTH=16, `transport_ready`=0, write 17 bytes → the 17th byte is dropped and `overflow`=1. After draining, the 16 delivered bytes match the first 16 written.
- 4 bytes buffered, phase changes 5→2 → `enable_receive`=0 next cycle, FIFO empty. On return to phase 5, `overflow` is cleared and no stale bytes are delivered.
- `reset` asserted mid-transfer with the FIFO half full → all outputs 0 next cycle, state IDLE. With `UL_EGRESS_STATS_EN`, `byte_count` = 0.

Source files
------------

// File: rtl/upper_layer_egress.sv
// Receive-side upper-layer egress: buffers descrambled lane bytes and delivers them to the
// transport layer with generation-dependent pacing. Define UL_EGRESS_STATS_EN to add byte_count.
module upper_layer_egress #(
  parameter int         DEPTH        = 16,
  parameter logic [2:0] ACTIVE_PHASE = 3'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  phase,
  input  logic [1:0]  generation_speed,
  input  logic [7:0]  lane_data_in,
  input  logic        lane_data_valid,
  output logic [7:0]  transport_layer_data_out,
  output logic        enable_receive,
  input  logic        transport_ready,
  output logic        overflow
`ifdef UL_EGRESS_STATS_EN
  ,
  output logic [15:0] byte_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            is_active, is_flush, enter_active;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [1:0]      pace_q, pace_d;
  logic [1:0]      pace_load;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d;
  logic            ovf_q, ovf_d;

  logic            full;
  logic            wr_en;
  logic            drop;
  logic            rd_en;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (phase == ACTIVE_PHASE) state_d = S_ACTIVE;
      S_ACTIVE: if (phase != ACTIVE_PHASE) state_d = S_FLUSH;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State decode.
  always_comb begin
    is_active    = (state_q == S_ACTIVE);
    is_flush     = (state_q == S_FLUSH);
    enter_active = (state_q == S_IDLE) && (state_d == S_ACTIVE);
  end

  // Fullness comes from registered occupancy, so a write into a full FIFO is dropped
  // even when a read frees a slot on the same edge.
  assign full  = (occ_q == OW'(DEPTH));
  assign wr_en = is_active && lane_data_valid && !full;
  assign drop  = is_active && lane_data_valid && full;
  assign rd_en = en_q && transport_ready;

  always_comb begin
    unique case (generation_speed)
      2'd0:    pace_load = 2'd3;
      2'd1:    pace_load = 2'd1;
      default: pace_load = 2'd0;
    endcase
  end

  // Datapath next state. The output stage is registered, so enable/data for the next
  // cycle look at what remains after this cycle's transfer and at the next pace value.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    pace_d   = pace_q;
    en_d     = 1'b0;
    data_d   = data_q;
    ovf_d    = ovf_q;

    if (is_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      pace_d   = '0;
      data_d   = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
      occ_d = occ_q + OW'(wr_en) - OW'(rd_en);

      if (rd_en)               pace_d = pace_load;
      else if (pace_q != 2'd0) pace_d = pace_q - 2'd1;

      // Bytes written this cycle are not yet eligible; that gives the one-cycle latency.
      en_d = is_active && ((occ_q - OW'(rd_en)) != '0) && (pace_d == 2'd0);
      if (en_d) data_d = mem_q[rd_ptr_d];
    end

    if (enter_active) ovf_d = 1'b0;
    else if (drop)    ovf_d = 1'b1;
  end

  // NOTE: the storage array has no reset; the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= lane_data_in;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      pace_q   <= '0;
      data_q   <= '0;
      en_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      pace_q   <= pace_d;
      data_q   <= data_d;
      en_q     <= en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign transport_layer_data_out = data_q;
  assign enable_receive           = en_q;
  assign overflow                 = ovf_q;

`ifdef UL_EGRESS_STATS_EN
  logic [15:0] byte_count_q;

  // Counts every accepted transfer; only reset clears it, so it survives FLUSH.
  always_ff @(posedge clk) begin
    if (reset)      byte_count_q <= '0;
    else if (rd_en) byte_count_q <= byte_count_q + 16'd1;
  end

  assign byte_count = byte_count_q;
`endif

endmodule
